// File: rtl/flash_phy_prim_pkg.sv
// Shared types and default geometry/timing for the flash primitive model.
// Struct widths follow the package geometry; latencies and bank count are top parameters.
package flash_phy_prim_pkg;

    localparam int unsigned DataWidth    = 64;
    localparam int unsigned WordsPerPage = 4;
    localparam int unsigned PagesPerBank = 4;
    localparam int unsigned Depth        = WordsPerPage * PagesPerBank;
    localparam int unsigned AddrW        = (Depth > 1) ? $clog2(Depth) : 1;

    localparam int unsigned DefNumBanks     = 2;
    localparam int unsigned DefRdLatency    = 2;
    localparam int unsigned DefProgLatency  = 4;
    localparam int unsigned DefEraseLatency = 8;

    typedef struct packed {
        logic                 rd;
        logic                 prog;
        logic                 pg_erase;
        logic                 bk_erase;
        logic [AddrW-1:0]     addr;
        logic [DataWidth-1:0] prog_data;
    } flash_phy_prim_flash_req_t;

    typedef struct packed {
        logic                 ack;
        logic                 done;
        logic                 err;
        logic                 busy;
        logic [DataWidth-1:0] rdata;
    } flash_phy_prim_flash_rsp_t;

    typedef enum logic [1:0] {
        OpRd,
        OpProg,
        OpPgErase,
        OpBkErase
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } bank_state_e;

    // Only meaningful for a one-hot {rd, prog, pg_erase, bk_erase} vector.
    function automatic op_e hot_to_op(input logic [3:0] hot);
        if (hot[3]) return OpRd;
        if (hot[2]) return OpProg;
        if (hot[1]) return OpPgErase;
        return OpBkErase;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flash_phy_prim_bank.sv
// One flash bank: request decode, latency counter, storage and response flops.
// Storage is reset to all-ones, which is the erased state of the array.
module flash_phy_prim_bank
    import flash_phy_prim_pkg::*;
#(
    parameter int unsigned RdLatency    = DefRdLatency,
    parameter int unsigned ProgLatency  = DefProgLatency,
    parameter int unsigned EraseLatency = DefEraseLatency
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  flash_phy_prim_flash_req_t req_i,
    output flash_phy_prim_flash_rsp_t rsp_o
);

    localparam int unsigned MaxLat = max3(RdLatency, ProgLatency, EraseLatency);
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    typedef logic [CntW-1:0] cnt_t;

    bank_state_e                      state_q, state_d;
    op_e                              op_q, op_d;
    logic [AddrW-1:0]                 addr_q, addr_d;
    logic [DataWidth-1:0]             data_q, data_d;
    cnt_t                             cnt_q, cnt_d;
    logic [Depth-1:0][DataWidth-1:0]  mem_q, mem_d;
    logic [DataWidth-1:0]             rdata_q, rdata_d;
    logic                             ack_q, ack_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;
    logic                             busy_q, busy_d;

    logic [3:0]                       op_hot;
    logic                             addr_ok;
    int unsigned                      page_sel;

    function automatic cnt_t load_cnt(input op_e op);
        case (op)
            OpRd:    return cnt_t'(RdLatency - 1);
            OpProg:  return cnt_t'(ProgLatency - 1);
            default: return cnt_t'(EraseLatency - 1);
        endcase
    endfunction

    assign op_hot   = {req_i.rd, req_i.prog, req_i.pg_erase, req_i.bk_erase};
    assign addr_ok  = 32'(req_i.addr) < Depth;
    assign page_sel = 32'(addr_q) / WordsPerPage;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            StBusy: begin
                if (cnt_q == '0) begin
                    // The commit is registered on the edge into DONE so that rdata
                    // and the new array contents are visible in the done cycle.
                    state_d = StDone;
                    done_d  = 1'b1;
                    case (op_q)
                        OpRd:   rdata_d = mem_q[addr_q];
                        OpProg: mem_d[addr_q] = mem_q[addr_q] & data_q;
                        OpPgErase: begin
                            for (int unsigned w = 0; w < Depth; w++) begin
                                if (w / WordsPerPage == page_sel) mem_d[w[AddrW-1:0]] = '1;
                            end
                        end
                        default: mem_d = '1;
                    endcase
                end else begin
                    cnt_d  = cnt_q - cnt_t'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and the single DONE cycle both accept a new request.
                state_d = StIdle;
                if (op_hot != '0) begin
                    ack_d = 1'b1;
                    if (!$onehot(op_hot) || !addr_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StBusy;
                        busy_d  = 1'b1;
                        op_d    = hot_to_op(op_hot);
                        addr_d  = req_i.addr;
                        data_d  = req_i.prog_data;
                        cnt_d   = load_cnt(hot_to_op(op_hot));
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= OpRd;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            mem_q   <= '1;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign rsp_o.ack   = ack_q;
    assign rsp_o.done  = done_q;
    assign rsp_o.err   = err_q;
    assign rsp_o.busy  = busy_q;
    assign rsp_o.rdata = rdata_q;

endmodule

// File: rtl/flash_phy_prim_model.sv
// Multi-bank flash primitive model standing in for the vendor macro under flash_phy.
// Banks share only clock and reset; each has its own request/response channel.
module flash_phy_prim_model
    import flash_phy_prim_pkg::*;
#(
    parameter int unsigned NumBanks     = DefNumBanks,
    parameter int unsigned RdLatency    = DefRdLatency,
    parameter int unsigned ProgLatency  = DefProgLatency,
    parameter int unsigned EraseLatency = DefEraseLatency
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  flash_phy_prim_flash_req_t [NumBanks-1:0] flash_req_i,
    output flash_phy_prim_flash_rsp_t [NumBanks-1:0] flash_rsp_o
);

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        flash_phy_prim_bank #(
            .RdLatency    (RdLatency),
            .ProgLatency  (ProgLatency),
            .EraseLatency (EraseLatency)
        ) u_bank (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (flash_req_i[b]),
            .rsp_o (flash_rsp_o[b])
        );
    end

endmodule
